// File: rtl/axi_lite_slave.sv
// ============================================================================
// axi_lite_slave
// ----------------------------------------------------------------------------
// Register-command front end between the processor register file and the
// image pipeline (RGB -> gray -> Sobel). On every clock edge where COMMANDER
// is high, the register selected by REG_ADDR is decoded into configuration
// outputs, BRAM read/write requests or pipeline start pulses. Read data
// returned by the BRAMs and the pipeline completion flags are collected in
// the STATUS word.
//
// Optional feature macro: AXI_SLAVE_RGB888_IN_EN
//   defined   : REG01 carries RGB888 and is reduced to RGB444 by keeping the
//               top nibble of each channel.
//   undefined : REG01[11:0] is used as the RGB444 pixel directly.
//
// Parameters
//   ADDR_W  BRAM address width (76800 pixels -> 17 bits)
//   RD_LAT  clocks from a read-request pulse to valid BRAM read data (>= 1)
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN        clock, async active-low reset
//   REG00..REG03, REG_ADDR, COMMANDER register file contents and strobe
//   THRESHOLD_TOP, ACCESS_CONTROL     configuration from REG02
//   AXI_WRDATA_COLOR_BRAM, AXI_WRREQUEST_COLOR_BRAM, AXI_WRADDR_2COLORBRAM,
//   AXI_RDREQUEST_COLORBRAM, AXI_RECV_DATA_FR_COLORBRAM  color BRAM access
//   DONE_WRITE_COLOR_BRAM_SIGN        color load finished level
//   AXI_START_RGB2GRAY, DONE_WRITE_GRAY_BRAM_SIGN        gray stage control
//   AXI_RDADDR_2GRAYBRAM, AXI_RDREQUEST_GRAYBRAM,
//   AXI_RECV_DATA_FR_GRAYBRAM         gray BRAM read
//   AXI_START_GRAY2SOBEL, DONE_PROCESSING_SOBEL          Sobel stage control
//   RD_REQUEST_FR_AXI, AXI_RDADDR_2SOBELBRAM, SOBEL_DATA_2AXI  Sobel read
//   STATUS  {capture_valid, sobel_done, gray_done, 17'b0, read_data[11:0]}
// ============================================================================
module axi_lite_slave #(
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 2
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic [31:0]       REG00,
    input  logic [31:0]       REG01,
    input  logic [31:0]       REG02,
    input  logic [31:0]       REG03,
    input  logic [1:0]        REG_ADDR,
    input  logic              COMMANDER,
    output logic [17:0]       THRESHOLD_TOP,
    output logic [1:0]        ACCESS_CONTROL,
    output logic [11:0]       AXI_WRDATA_COLOR_BRAM,
    output logic              AXI_WRREQUEST_COLOR_BRAM,
    output logic              DONE_WRITE_COLOR_BRAM_SIGN,
    output logic [ADDR_W-1:0] AXI_WRADDR_2COLORBRAM,
    output logic              AXI_RDREQUEST_COLORBRAM,
    input  logic [11:0]       AXI_RECV_DATA_FR_COLORBRAM,
    output logic              AXI_START_RGB2GRAY,
    input  logic              DONE_WRITE_GRAY_BRAM_SIGN,
    output logic [ADDR_W-1:0] AXI_RDADDR_2GRAYBRAM,
    output logic              AXI_RDREQUEST_GRAYBRAM,
    input  logic [7:0]        AXI_RECV_DATA_FR_GRAYBRAM,
    output logic              AXI_START_GRAY2SOBEL,
    input  logic              DONE_PROCESSING_SOBEL,
    output logic              RD_REQUEST_FR_AXI,
    output logic [ADDR_W-1:0] AXI_RDADDR_2SOBELBRAM,
    input  logic [7:0]        SOBEL_DATA_2AXI,
    output logic [31:0]       STATUS
);

    // Counter wide enough to hold RD_LAT; it counts down to the capture edge.
    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Which BRAM the outstanding read was issued to.
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_COLOR = 2'd1,
        SRC_GRAY  = 2'd2,
        SRC_SOBEL = 2'd3
    } rd_src_e;

    logic [17:0]       thr_q,         thr_d;
    logic [1:0]        acc_q,         acc_d;
    logic [11:0]       pix_q,         pix_d;
    logic [11:0]       wdata_q,       wdata_d;
    logic [ADDR_W-1:0] caddr_q,       caddr_d;
    logic [ADDR_W-1:0] gaddr_q,       gaddr_d;
    logic [ADDR_W-1:0] saddr_q,       saddr_d;
    logic              wr_req_q,      wr_req_d;
    logic              crd_req_q,     crd_req_d;
    logic              grd_req_q,     grd_req_d;
    logic              srd_req_q,     srd_req_d;
    logic              start_gray_q,  start_gray_d;
    logic              start_sobel_q, start_sobel_d;
    logic              done_color_q,  done_color_d;
    rd_src_e           rd_src_q,      rd_src_d;
    logic [CNT_W-1:0]  rd_cnt_q,      rd_cnt_d;
    logic [11:0]       rdata_q,       rdata_d;
    logic              cap_q,         cap_d;
    logic              gray_done_q,   gray_done_d;
    logic              sobel_done_q,  sobel_done_d;

    logic [ADDR_W-1:0] cmd_addr_s;
    logic [11:0]       pixel_in_s;
    logic              capture_s;
    logic              gray_clr_s;
    logic              sobel_clr_s;
    logic              unused_s;

    assign cmd_addr_s = REG00[ADDR_W-1:0];

`ifdef AXI_SLAVE_RGB888_IN_EN
    // Keep the top nibble of each RGB888 channel.
    assign pixel_in_s = {REG01[23:20], REG01[15:12], REG01[7:4]};
`else
    assign pixel_in_s = REG01[11:0];
`endif

    // Register bits with no function in this block.
    assign unused_s = ^{REG00[31:25], REG01, REG02[29:18], REG03};

    // Next-state decode of commands, read capture and sticky flags.
    always_comb begin
        thr_d         = thr_q;
        acc_d         = acc_q;
        pix_d         = pix_q;
        wdata_d       = wdata_q;
        caddr_d       = caddr_q;
        gaddr_d       = gaddr_q;
        saddr_d       = saddr_q;
        done_color_d  = done_color_q;
        wr_req_d      = 1'b0;
        crd_req_d     = 1'b0;
        grd_req_d     = 1'b0;
        srd_req_d     = 1'b0;
        start_gray_d  = 1'b0;
        start_sobel_d = 1'b0;
        rd_src_d      = rd_src_q;
        rd_cnt_d      = rd_cnt_q;
        rdata_d       = rdata_q;
        cap_d         = cap_q;
        gray_clr_s    = 1'b0;
        sobel_clr_s   = 1'b0;
        capture_s     = (rd_cnt_q == CNT_ONE);

        if (capture_s) begin
            rd_cnt_d = CNT_ZERO;
        end else if (rd_cnt_q != CNT_ZERO) begin
            rd_cnt_d = rd_cnt_q - CNT_ONE;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end

        // A capture on the same edge as a command keeps the valid flag set,
        // so the freshly captured word is never lost.
        if (capture_s) begin
            cap_d = 1'b1;
            case (rd_src_q)
                SRC_COLOR: rdata_d = AXI_RECV_DATA_FR_COLORBRAM;
                SRC_GRAY:  rdata_d = {4'd0, AXI_RECV_DATA_FR_GRAYBRAM};
                SRC_SOBEL: rdata_d = {4'd0, SOBEL_DATA_2AXI};
                default:   rdata_d = rdata_q;
            endcase
        end else if (COMMANDER) begin
            cap_d = 1'b0;
        end else begin
            cap_d = cap_q;
        end

        if (COMMANDER) begin
            case (REG_ADDR)
                2'd0: begin
                    // Priority-encoded: exactly one action per command.
                    // A read loads the countdown, restarting any pending one.
                    if (REG00[18] && REG00[17]) begin
                        caddr_d  = cmd_addr_s;
                        wdata_d  = pix_q;
                        wr_req_d = 1'b1;
                    end else if (REG00[18]) begin
                        caddr_d   = cmd_addr_s;
                        crd_req_d = 1'b1;
                        rd_src_d  = SRC_COLOR;
                        rd_cnt_d  = CNT_LOAD;
                    end else if (REG00[19]) begin
                        gaddr_d   = cmd_addr_s;
                        grd_req_d = 1'b1;
                        rd_src_d  = SRC_GRAY;
                        rd_cnt_d  = CNT_LOAD;
                    end else if (REG00[20]) begin
                        saddr_d   = cmd_addr_s;
                        srd_req_d = 1'b1;
                        rd_src_d  = SRC_SOBEL;
                        rd_cnt_d  = CNT_LOAD;
                    end else if (REG00[21]) begin
                        start_gray_d = 1'b1;
                        gray_clr_s   = 1'b1;
                    end else if (REG00[22]) begin
                        start_sobel_d = 1'b1;
                        sobel_clr_s   = 1'b1;
                    end else if (REG00[23]) begin
                        done_color_d = 1'b1;
                    end else if (REG00[24]) begin
                        done_color_d = 1'b0;
                    end else begin
                        done_color_d = done_color_q;
                    end
                end
                2'd1: begin
                    pix_d = pixel_in_s;
                end
                2'd2: begin
                    thr_d = REG02[17:0];
                    acc_d = REG02[31:30];
                end
                default: begin
                    // REG03 is reserved: nothing is decoded.
                    pix_d = pix_q;
                end
            endcase
        end else begin
            pix_d = pix_q;
        end

        // Sticky done flags: a set in the same cycle beats the start's clear.
        gray_done_d  = DONE_WRITE_GRAY_BRAM_SIGN ? 1'b1 :
                       (gray_clr_s ? 1'b0 : gray_done_q);
        sobel_done_d = DONE_PROCESSING_SOBEL ? 1'b1 :
                       (sobel_clr_s ? 1'b0 : sobel_done_q);
    end

    // State and output registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            thr_q         <= 18'd0;
            acc_q         <= 2'd0;
            pix_q         <= 12'd0;
            wdata_q       <= 12'd0;
            caddr_q       <= {ADDR_W{1'b0}};
            gaddr_q       <= {ADDR_W{1'b0}};
            saddr_q       <= {ADDR_W{1'b0}};
            wr_req_q      <= 1'b0;
            crd_req_q     <= 1'b0;
            grd_req_q     <= 1'b0;
            srd_req_q     <= 1'b0;
            start_gray_q  <= 1'b0;
            start_sobel_q <= 1'b0;
            done_color_q  <= 1'b0;
            rd_src_q      <= SRC_NONE;
            rd_cnt_q      <= CNT_ZERO;
            rdata_q       <= 12'd0;
            cap_q         <= 1'b0;
            gray_done_q   <= 1'b0;
            sobel_done_q  <= 1'b0;
        end else begin
            thr_q         <= thr_d;
            acc_q         <= acc_d;
            pix_q         <= pix_d;
            wdata_q       <= wdata_d;
            caddr_q       <= caddr_d;
            gaddr_q       <= gaddr_d;
            saddr_q       <= saddr_d;
            wr_req_q      <= wr_req_d;
            crd_req_q     <= crd_req_d;
            grd_req_q     <= grd_req_d;
            srd_req_q     <= srd_req_d;
            start_gray_q  <= start_gray_d;
            start_sobel_q <= start_sobel_d;
            done_color_q  <= done_color_d;
            rd_src_q      <= rd_src_d;
            rd_cnt_q      <= rd_cnt_d;
            rdata_q       <= rdata_d;
            cap_q         <= cap_d;
            gray_done_q   <= gray_done_d;
            sobel_done_q  <= sobel_done_d;
        end
    end

    assign THRESHOLD_TOP              = thr_q;
    assign ACCESS_CONTROL             = acc_q;
    assign AXI_WRDATA_COLOR_BRAM      = wdata_q;
    assign AXI_WRREQUEST_COLOR_BRAM   = wr_req_q;
    assign DONE_WRITE_COLOR_BRAM_SIGN = done_color_q;
    assign AXI_WRADDR_2COLORBRAM      = caddr_q;
    assign AXI_RDREQUEST_COLORBRAM    = crd_req_q;
    assign AXI_START_RGB2GRAY         = start_gray_q;
    assign AXI_RDADDR_2GRAYBRAM       = gaddr_q;
    assign AXI_RDREQUEST_GRAYBRAM     = grd_req_q;
    assign AXI_START_GRAY2SOBEL       = start_sobel_q;
    assign RD_REQUEST_FR_AXI          = srd_req_q;
    assign AXI_RDADDR_2SOBELBRAM      = saddr_q;
    assign STATUS = {cap_q, sobel_done_q, gray_done_q, 17'd0, rdata_q};

endmodule

// File: tb/tb_axi_lite_slave.sv
// ============================================================================
// tb_axi_lite_slave
// Self-checking bench for axi_lite_slave: directed scenarios with literal
// expectations, then randomized commands, all compared every cycle against a
// behavioural model that tracks outstanding reads by cycle stamp.
// ============================================================================
module tb_axi_lite_slave;
    localparam int ADDR_W = 17;
    localparam int RD_LAT = 2;
`ifdef AXI_SLAVE_RGB888_IN_EN
    localparam logic [11:0] EXP_PIX = 12'hACE;
`else
    localparam logic [11:0] EXP_PIX = 12'hDEF;
`endif

    logic              clk = 1'b1;
    logic              rst_n = 1'b0;
    logic [31:0]       reg00, reg01, reg02, reg03;
    logic [1:0]        reg_addr;
    logic              commander;
    logic [11:0]       color_rd;
    logic [7:0]        gray_rd, sobel_rd;
    logic              done_gray, done_sobel;

    logic [17:0]       thr_o;
    logic [1:0]        acc_o;
    logic [11:0]       wdata_o;
    logic              wr_o, done_color_o, crd_o, stg_o, grd_o, sts_o, srd_o;
    logic [ADDR_W-1:0] caddr_o, gaddr_o, saddr_o;
    logic [31:0]       status_o;

    int n_checks = 0;
    int n_errors = 0;
    int wr_seen  = 0;
    bit chk_en   = 1'b0;

    // behavioural model state
    logic [17:0]       m_thr;
    logic [1:0]        m_acc;
    logic [11:0]       m_pix, m_wdata, m_data;
    logic [ADDR_W-1:0] m_caddr, m_gaddr, m_saddr;
    logic              m_wr, m_crd, m_grd, m_srd, m_stg, m_sts, m_done_color;
    logic              m_cap, m_gray, m_sob;
    bit                m_pend;
    int                m_pend_cyc, m_pend_src, m_cyc;

    always #5 clk = ~clk;

    axi_lite_slave #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .S_AXI_ACLK                 (clk),
        .S_AXI_ARESETN              (rst_n),
        .REG00                      (reg00),
        .REG01                      (reg01),
        .REG02                      (reg02),
        .REG03                      (reg03),
        .REG_ADDR                   (reg_addr),
        .COMMANDER                  (commander),
        .THRESHOLD_TOP              (thr_o),
        .ACCESS_CONTROL             (acc_o),
        .AXI_WRDATA_COLOR_BRAM      (wdata_o),
        .AXI_WRREQUEST_COLOR_BRAM   (wr_o),
        .DONE_WRITE_COLOR_BRAM_SIGN (done_color_o),
        .AXI_WRADDR_2COLORBRAM      (caddr_o),
        .AXI_RDREQUEST_COLORBRAM    (crd_o),
        .AXI_RECV_DATA_FR_COLORBRAM (color_rd),
        .AXI_START_RGB2GRAY         (stg_o),
        .DONE_WRITE_GRAY_BRAM_SIGN  (done_gray),
        .AXI_RDADDR_2GRAYBRAM       (gaddr_o),
        .AXI_RDREQUEST_GRAYBRAM     (grd_o),
        .AXI_RECV_DATA_FR_GRAYBRAM  (gray_rd),
        .AXI_START_GRAY2SOBEL       (sts_o),
        .DONE_PROCESSING_SOBEL      (done_sobel),
        .RD_REQUEST_FR_AXI          (srd_o),
        .AXI_RDADDR_2SOBELBRAM      (saddr_o),
        .SOBEL_DATA_2AXI            (sobel_rd),
        .STATUS                     (status_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_pixel(input logic [31:0] r);
`ifdef AXI_SLAVE_RGB888_IN_EN
        return {r[23:20], r[15:12], r[7:4]};
`else
        return r[11:0];
`endif
    endfunction

    function automatic logic [31:0] model_status();
        return {m_cap, m_sob, m_gray, 17'd0, m_data};
    endfunction

    task automatic model_reset();
        m_thr = '0; m_acc = '0; m_pix = '0; m_wdata = '0; m_data = '0;
        m_caddr = '0; m_gaddr = '0; m_saddr = '0;
        m_wr = 0; m_crd = 0; m_grd = 0; m_srd = 0; m_stg = 0; m_sts = 0;
        m_done_color = 0; m_cap = 0; m_gray = 0; m_sob = 0;
        m_pend = 0; m_pend_cyc = 0; m_pend_src = 0;
    endtask

    task automatic start_read(input int src);
        m_pend = 1; m_pend_cyc = m_cyc; m_pend_src = src;
    endtask

    // Model of one clock edge, using the inputs present at that edge.
    task automatic model_step();
        logic [ADDR_W-1:0] a;
        bit clr_g, clr_s;
        m_cyc++;
        clr_g = 0; clr_s = 0;
        m_wr = 0; m_crd = 0; m_grd = 0; m_srd = 0; m_stg = 0; m_sts = 0;
        if (m_pend && m_cyc == m_pend_cyc + RD_LAT) begin
            m_pend = 0;
            m_cap  = 1;
            if (m_pend_src == 0)      m_data = color_rd;
            else if (m_pend_src == 1) m_data = {4'd0, gray_rd};
            else                      m_data = {4'd0, sobel_rd};
        end else if (commander) begin
            m_cap = 0;
        end
        if (commander && reg_addr == 2'd0) begin
            a = reg00[ADDR_W-1:0];
            if (reg00[18] && reg00[17]) begin m_caddr = a; m_wdata = m_pix; m_wr = 1; end
            else if (reg00[18]) begin m_caddr = a; m_crd = 1; start_read(0); end
            else if (reg00[19]) begin m_gaddr = a; m_grd = 1; start_read(1); end
            else if (reg00[20]) begin m_saddr = a; m_srd = 1; start_read(2); end
            else if (reg00[21]) begin m_stg = 1; clr_g = 1; end
            else if (reg00[22]) begin m_sts = 1; clr_s = 1; end
            else if (reg00[23]) m_done_color = 1;
            else if (reg00[24]) m_done_color = 0;
        end else if (commander && reg_addr == 2'd1) begin
            m_pix = model_pixel(reg01);
        end else if (commander && reg_addr == 2'd2) begin
            m_thr = reg02[17:0];
            m_acc = reg02[31:30];
        end
        if (done_gray)  m_gray = 1; else if (clr_g) m_gray = 0;
        if (done_sobel) m_sob  = 1; else if (clr_s) m_sob  = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic issue(input logic [1:0] ra, input logic [31:0] val);
        reg_addr  = ra;
        commander = 1'b1;
        case (ra)
            2'd0:    reg00 = val;
            2'd1:    reg01 = val;
            2'd2:    reg02 = val;
            default: reg03 = val;
        endcase
        cycle();
        commander = 1'b0;
    endtask

    task automatic idle();
        commander = 1'b0;
        cycle();
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (wr_o === 1'b1) wr_seen++;
            check("thr",        32'(thr_o),        32'(m_thr));
            check("acc",        32'(acc_o),        32'(m_acc));
            check("wdata",      32'(wdata_o),      32'(m_wdata));
            check("wr_req",     32'(wr_o),         32'(m_wr));
            check("done_color", 32'(done_color_o), 32'(m_done_color));
            check("caddr",      32'(caddr_o),      32'(m_caddr));
            check("crd_req",    32'(crd_o),        32'(m_crd));
            check("start_gray", 32'(stg_o),        32'(m_stg));
            check("gaddr",      32'(gaddr_o),      32'(m_gaddr));
            check("grd_req",    32'(grd_o),        32'(m_grd));
            check("start_sob",  32'(sts_o),        32'(m_sts));
            check("srd_req",    32'(srd_o),        32'(m_srd));
            check("saddr",      32'(saddr_o),      32'(m_saddr));
            check("status",     status_o,          model_status());
        end
    end

    task automatic run_load();
        int a;
        for (int k = 0; k < 1024; k++) begin
            a = (k < 512) ? k : 76288 + (k - 512);
            issue(2'd0, 32'h0006_0000 | 32'(a));
            check("load_addr", 32'(caddr_o), 32'(a));
        end
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            commander  = 1'($urandom_range(0, 1));
            reg_addr   = 2'($urandom_range(0, 3));
            reg00      = $urandom;
            reg01      = $urandom;
            reg02      = $urandom;
            reg03      = $urandom;
            color_rd   = 12'($urandom);
            gray_rd    = 8'($urandom);
            sobel_rd   = 8'($urandom);
            done_gray  = ($urandom_range(0, 7) == 0);
            done_sobel = ($urandom_range(0, 7) == 0);
            cycle();
        end
        commander = 1'b0; done_gray = 1'b0; done_sobel = 1'b0;
    endtask

    initial begin
        reg00 = '0; reg01 = '0; reg02 = '0; reg03 = '0; reg_addr = '0;
        commander = 1'b0; color_rd = '0; gray_rd = '0; sobel_rd = '0;
        done_gray = 1'b0; done_sobel = 1'b0;
        m_cyc = 0;
        model_reset();

        // reset state
        #12;
        check("rst_status", status_o, 32'h0);
        check("rst_cfg",    {12'd0, thr_o, acc_o}, 32'h0);
        check("rst_addr",   32'(caddr_o) | 32'(gaddr_o) | 32'(saddr_o), 32'h0);
        check("rst_pulses", {25'd0, wr_o, crd_o, grd_o, srd_o, stg_o, sts_o, done_color_o}, 32'h0);
        check("rst_wdata",  32'(wdata_o), 32'h0);
        #3 rst_n = 1'b1;
        chk_en = 1'b1;

        // threshold and ownership
        issue(2'd2, 32'h0000_C350);
        check("thr_val", 32'(thr_o), 32'h0_C350);
        check("thr_model", 32'(m_thr), 32'h0_C350);
        check("acc_00", 32'(acc_o), 32'h0);
        issue(2'd2, 32'hC000_C350);
        check("acc_11", 32'(acc_o), 32'h3);
        check("thr_hold", 32'(thr_o), 32'h0_C350);

        // single color write
        issue(2'd1, 32'h00AB_CDEF);
        check("wr_none_on_reg01", 32'(wr_o), 32'h0);
        issue(2'd0, 32'h0006_0005);
        check("cw_pulse", 32'(wr_o), 32'h1);
        check("cw_addr",  32'(caddr_o), 32'h5);
        check("cw_data",  32'(wdata_o), 32'(EXP_PIX));
        check("cw_model_data", 32'(m_wdata), 32'(EXP_PIX));
        idle();
        check("cw_pulse_width", 32'(wr_o), 32'h0);

        // ascending load, back-to-back pulses
        run_load();
        idle();
        check("load_pulse_count", 32'(wr_seen), 32'd1025);
        check("load_last_addr",   32'(caddr_o), 32'd76799);
        issue(2'd0, 32'h0080_0000);
        check("done_color_set", 32'(done_color_o), 32'h1);

        // gray pipeline
        issue(2'd0, 32'h0020_0000);
        check("start_gray_pulse", 32'(stg_o), 32'h1);
        idle();
        check("start_gray_width", 32'(stg_o), 32'h0);
        done_gray = 1'b1;
        idle();
        check("gray_sticky_set", 32'(status_o[29]), 32'h1);
        done_gray = 1'b0;
        idle(); idle();
        check("gray_sticky_hold", 32'(status_o[29]), 32'h1);
        issue(2'd0, 32'h0020_0000);
        check("gray_sticky_clr", 32'(status_o[29]), 32'h0);
        gray_rd = 8'h5A;
        issue(2'd0, 32'h0008_0064);
        check("grd_pulse", 32'(grd_o), 32'h1);
        check("grd_addr",  32'(gaddr_o), 32'd100);
        idle();
        check("grd_lat1", status_o, 32'h0);
        idle();
        check("grd_capture", status_o, 32'h8000_005A);
        check("grd_capture_model", model_status(), 32'h8000_005A);
        issue(2'd3, 32'h0);
        check("cap_flag_clr", status_o, 32'h0000_005A);

        // priority: color write beats start gray
        issue(2'd0, 32'h0026_0007);
        check("prio_wr",    32'(wr_o), 32'h1);
        check("prio_start", 32'(stg_o), 32'h0);
        check("prio_addr",  32'(caddr_o), 32'h7);

        // raw address beyond the image passes through
        issue(2'd0, 32'h0005_FFFF);
        check("addr_max", 32'(caddr_o), 32'h1_FFFF);
        issue(2'd0, 32'h0100_0000);
        check("done_color_clr", 32'(done_color_o), 32'h0);

        // Sobel sticky, set wins over same-cycle clear
        done_sobel = 1'b1;
        idle();
        check("sobel_set", 32'(status_o[30]), 32'h1);
        issue(2'd0, 32'h0040_0000);
        check("sobel_start_pulse", 32'(sts_o), 32'h1);
        check("sobel_set_wins", 32'(status_o[30]), 32'h1);
        done_sobel = 1'b0;
        issue(2'd0, 32'h0040_0000);
        check("sobel_clr", 32'(status_o[30]), 32'h0);

        run_random(3000);
        idle(); idle(); idle();

        // reset mid-read: pulse drops immediately, capture discarded
        gray_rd = 8'h33;
        issue(2'd0, 32'h0008_0010);
        check("mid_pulse_before", 32'(grd_o), 32'h1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_pulse_low",  32'(grd_o), 32'h0);
        check("mid_status_low", status_o, 32'h0);
        #5 rst_n = 1'b1;
        idle(); idle(); idle();
        check("mid_no_capture", status_o, 32'h0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
